// File: rtl/margin_regbank.sv
// Top-K smallest-margin register bank: keeps N_REGISTERS entries, tracks the largest one
// for the external comparator via a sequential scan, and streams all slots out on request.
module margin_regbank #(
    parameter int DATA_WIDTH  = 16,
    parameter int INDX_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 2,
    parameter int N_REGISTERS = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     s_valid,
    output logic                                     s_ready,
    input  logic                                     cmp_trig,
    input  logic [ADDR_WIDTH-1:0]                    cmp_rsel,
    input  logic [DATA_WIDTH+INDX_WIDTH+ADDR_WIDTH-1:0] cmp_dout,
    output logic [DATA_WIDTH+INDX_WIDTH+ADDR_WIDTH-1:0] max_out,
    input  logic                                     rd_start,
    input  logic                                     clr,
    output logic                                     m_valid,
    input  logic                                     m_ready,
    output logic [DATA_WIDTH+INDX_WIDTH+ADDR_WIDTH-1:0] m_data,
    output logic                                     m_last,
    output logic                                     busy
);

    localparam int EW = DATA_WIDTH + INDX_WIDTH + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(N_REGISTERS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        READ = 2'd2
    } state_t;

    state_t                r_state;
    logic [EW-1:0]         r_slot [N_REGISTERS];
    logic [EW-1:0]         r_run;
    logic [EW-1:0]         r_max;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_s_ready;
    logic                  r_busy;
    logic                  r_m_valid;
    logic [EW-1:0]         r_m_data;
    logic                  r_m_last;

    logic [EW-1:0]         w_cand;
    logic [EW-1:0]         w_best;
    logic [ADDR_WIDTH-1:0] w_ptr_nxt;
    logic [ADDR_WIDTH-1:0] w_unused_addr;

    function automatic logic [EW-1:0] f_init_entry(input int i);
        logic [ADDR_WIDTH-1:0] a;
        a = ADDR_WIDTH'(i);
        return {a, {INDX_WIDTH{1'b0}}, {DATA_WIDTH{1'b1}}};
    endfunction

    // The incoming address bits are replaced by cmp_rsel on write.
    assign w_unused_addr = cmp_dout[EW-1:DATA_WIDTH+INDX_WIDTH];
    assign w_ptr_nxt     = r_ptr + ADDR_WIDTH'(1);

    // Scan step: slot 0 seeds the running max; later slots win only on a strictly larger margin.
    always_comb begin
        w_cand = r_slot[r_ptr];
        w_best = r_run;
        if (r_ptr == '0) begin
            w_best = w_cand;
        end else if (w_cand[DATA_WIDTH-1:0] > r_run[DATA_WIDTH-1:0]) begin
            w_best = w_cand;
        end else begin
            w_best = r_run;
        end
    end

    // Control FSM, slot storage and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            for (int i = 0; i < N_REGISTERS; i++) r_slot[i] <= f_init_entry(i);
            r_run     <= '0;
            r_max     <= f_init_entry(0);
            r_ptr     <= '0;
            r_s_ready <= 1'b1;
            r_busy    <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (clr) begin
                        for (int i = 0; i < N_REGISTERS; i++) r_slot[i] <= f_init_entry(i);
                        r_max <= f_init_entry(0);
                    end else if (s_valid && cmp_trig) begin
                        r_slot[cmp_rsel] <= {cmp_rsel, cmp_dout[DATA_WIDTH+INDX_WIDTH-1:0]};
                        r_state   <= SCAN;
                        r_ptr     <= '0;
                        r_s_ready <= 1'b0;
                        r_busy    <= 1'b1;
                    end else if (rd_start) begin
                        r_state   <= READ;
                        r_ptr     <= '0;
                        r_s_ready <= 1'b0;
                        r_busy    <= 1'b1;
                        r_m_valid <= 1'b1;
                        r_m_data  <= r_slot[0];
                        r_m_last  <= (N_REGISTERS == 1);
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SCAN: begin
                    r_run <= w_best;
                    if (r_ptr == LAST_PTR) begin
                        r_max     <= w_best;
                        r_state   <= IDLE;
                        r_ptr     <= '0;
                        r_s_ready <= 1'b1;
                        r_busy    <= 1'b0;
                    end else begin
                        r_ptr <= w_ptr_nxt;
                    end
                end
                READ: begin
                    if (m_ready) begin
                        if (r_ptr == LAST_PTR) begin
                            r_state   <= IDLE;
                            r_ptr     <= '0;
                            r_s_ready <= 1'b1;
                            r_busy    <= 1'b0;
                            r_m_valid <= 1'b0;
                            r_m_last  <= 1'b0;
                        end else begin
                            r_ptr    <= w_ptr_nxt;
                            r_m_data <= r_slot[w_ptr_nxt];
                            r_m_last <= (w_ptr_nxt == LAST_PTR);
                        end
                    end else begin
                        r_ptr <= r_ptr;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_ptr     <= '0;
                    r_s_ready <= 1'b1;
                    r_busy    <= 1'b0;
                    r_m_valid <= 1'b0;
                    r_m_last  <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready = r_s_ready;
    assign busy    = r_busy;
    assign max_out = r_max;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_last  = r_m_last;

endmodule

// File: tb/tb_margin_regbank.sv
// Randomized self-checking bench for margin_regbank against an array-based top-K model.
module tb_margin_regbank;

    localparam int D  = 16;
    localparam int I  = 8;
    localparam int A  = 2;
    localparam int N  = 4;
    localparam int EW = D + I + A;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          cmp_trig = 1'b0;
    logic [A-1:0]  cmp_rsel = '0;
    logic [EW-1:0] cmp_dout = '0;
    logic [EW-1:0] max_out;
    logic          rd_start = 1'b0;
    logic          clr = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [EW-1:0] m_data;
    logic          m_last;
    logic          busy;

    int total = 0;
    int bad   = 0;

    int unsigned mdl_margin [N];
    int unsigned mdl_idx    [N];

    logic [EW-1:0] got_data [8];
    logic          got_last [8];
    int            got_n;
    bit            stall_ok;
    bit            read_to;

    margin_regbank #(.DATA_WIDTH(D), .INDX_WIDTH(I), .ADDR_WIDTH(A), .N_REGISTERS(N)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .cmp_trig(cmp_trig),
        .cmp_rsel(cmp_rsel), .cmp_dout(cmp_dout), .max_out(max_out), .rd_start(rd_start),
        .clr(clr), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void mdl_reset();
        for (int i = 0; i < N; i++) begin
            mdl_margin[i] = 32'hFFFF;
            mdl_idx[i]    = 0;
        end
    endfunction

    function automatic logic [EW-1:0] mdl_entry(input int i);
        return {A'(i), I'(mdl_idx[i]), D'(mdl_margin[i])};
    endfunction

    // Largest margin wins; the first (lowest address) of equal margins is kept.
    function automatic logic [EW-1:0] mdl_max();
        int best = 0;
        for (int i = 1; i < N; i++) if (mdl_margin[i] > mdl_margin[best]) best = i;
        return mdl_entry(best);
    endfunction

    task automatic do_write(input int rsel, input int idx, input int margin, input int junk,
                            input bit with_rd, output int cyc, output bit held);
        logic [EW-1:0] prev;
        prev     = mdl_max();
        s_valid  = 1'b1;
        cmp_trig = 1'b1;
        rd_start = with_rd;
        cmp_rsel = A'(rsel);
        cmp_dout = {A'(junk), I'(idx), D'(margin)};
        step();
        s_valid  = 1'b0;
        cmp_trig = 1'b0;
        rd_start = 1'b0;
        mdl_margin[rsel] = margin;
        mdl_idx[rsel]    = idx;
        cyc  = 0;
        held = 1'b1;
        while (busy && cyc < 20) begin
            if (max_out !== prev) held = 1'b0;
            cyc++;
            step();
        end
    endtask

    task automatic collect_read(input logic [15:0] pat, input bit noise);
        logic [EW-1:0] stall_data;
        logic          stall_last;
        bit            have_stall = 1'b0;
        int            c = 0;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        got_n    = 0;
        stall_ok = 1'b1;
        stall_data = '0;
        stall_last = 1'b0;
        while (m_valid && c < 40) begin
            if (noise) begin
                clr      = 1'b1;
                s_valid  = 1'b1;
                cmp_trig = 1'b1;
                rd_start = 1'b1;
                cmp_rsel = A'($urandom_range(0, N - 1));
                cmp_dout = EW'($urandom);
            end
            m_ready = (c < 16) ? pat[c] : 1'b1;
            if (have_stall && (m_data !== stall_data || m_last !== stall_last)) stall_ok = 1'b0;
            if (m_ready) begin
                if (got_n < 8) begin
                    got_data[got_n] = m_data;
                    got_last[got_n] = m_last;
                end
                got_n++;
                have_stall = 1'b0;
            end else begin
                have_stall = 1'b1;
                stall_data = m_data;
                stall_last = m_last;
            end
            step();
            c++;
        end
        clr      = 1'b0;
        s_valid  = 1'b0;
        cmp_trig = 1'b0;
        rd_start = 1'b0;
        m_ready  = 1'b0;
        read_to  = (c >= 40);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        mdl_reset();
        total++; if (max_out !== 26'h000FFFF) begin bad++; $display("FAIL reset_max got=%h exp=%h", max_out, 26'h000FFFF); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (m_valid !== 1'b0 || m_last !== 1'b0) begin bad++; $display("FAIL reset_m got=%b%b exp=00", m_valid, m_last); end
    endtask

    task automatic test_single_write();
        int cyc;
        bit held;
        do_write(0, 5, 16'h0010, 3, 1'b0, cyc, held);
        total++; if (cyc !== 4) begin bad++; $display("FAIL single_scan_len got=%0d exp=4", cyc); end
        total++; if (!held) begin bad++; $display("FAIL single_max_hold got=changed exp=held"); end
        total++; if (max_out !== 26'h100FFFF) begin bad++; $display("FAIL single_max got=%h exp=%h", max_out, 26'h100FFFF); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL single_s_ready got=%b exp=1", s_ready); end
    endtask

    task automatic test_fill();
        int cyc;
        bit held;
        logic [EW-1:0] exp_max;
        int margins [N] = '{32'h30, 32'h10, 32'h20, 32'h40};
        for (int i = 0; i < N; i++) begin
            do_write(i, i + 1, margins[i], 0, 1'b0, cyc, held);
            total++; if (cyc !== 4 || !held) begin bad++; $display("FAIL fill_scan got=%0d/%0d exp=4/1", cyc, held); end
        end
        exp_max = {2'd3, 8'd4, 16'h0040};
        total++; if (max_out !== exp_max) begin bad++; $display("FAIL fill_max got=%h exp=%h", max_out, exp_max); end
        total++; if (mdl_max() !== exp_max) begin bad++; $display("FAIL fill_model got=%h exp=%h", mdl_max(), exp_max); end
        for (int c = 0; c < 3; c++) begin
            s_valid  = 1'b1;
            cmp_trig = 1'b0;
            cmp_rsel = A'(c);
            cmp_dout = EW'($urandom);
            step();
            total++; if (s_ready !== 1'b1 || busy !== 1'b0 || max_out !== exp_max) begin
                bad++; $display("FAIL no_trig got=%b/%b/%h exp=1/0/%h", s_ready, busy, max_out, exp_max);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic test_readout();
        collect_read(16'hFFFD, 1'b0);
        total++; if (read_to || got_n !== N) begin bad++; $display("FAIL read_beats got=%0d exp=%0d", got_n, N); end
        for (int i = 0; i < N && i < got_n; i++) begin
            total++; if (got_data[i] !== mdl_entry(i) || got_last[i] !== (i == N - 1)) begin
                bad++; $display("FAIL read_beat%0d got=%h/%b exp=%h/%b", i, got_data[i], got_last[i], mdl_entry(i), i == N - 1);
            end
        end
        total++; if (!stall_ok) begin bad++; $display("FAIL read_stall got=unstable exp=stable"); end
        total++; if (busy !== 1'b0 || s_ready !== 1'b1 || m_valid !== 1'b0) begin
            bad++; $display("FAIL read_idle got=%b/%b/%b exp=0/1/0", busy, s_ready, m_valid);
        end
    endtask

    task automatic test_random();
        int cyc;
        bit held;
        int op;
        logic [EW-1:0] exp_max;
        for (int n = 0; n < 30; n++) begin
            op = $urandom_range(0, 3);
            if (op <= 1) begin
                do_write($urandom_range(0, N - 1), $urandom_range(0, 255),
                         (($urandom_range(0, 7) == 0) ? 32'hFFFF : $urandom_range(0, 65535)),
                         $urandom_range(0, 3), op == 1, cyc, held);
                exp_max = mdl_max();
                total++; if (cyc !== 4 || !held || max_out !== exp_max || m_valid !== 1'b0) begin
                    bad++; $display("FAIL rand_write got=%0d/%0d/%h/%b exp=4/1/%h/0", cyc, held, max_out, m_valid, exp_max);
                end
            end else if (op == 2) begin
                s_valid  = 1'b1;
                cmp_trig = 1'b0;
                cmp_dout = EW'($urandom);
                step();
                s_valid = 1'b0;
                total++; if (s_ready !== 1'b1 || busy !== 1'b0 || max_out !== mdl_max()) begin
                    bad++; $display("FAIL rand_no_trig got=%b/%b/%h exp=1/0/%h", s_ready, busy, max_out, mdl_max());
                end
            end else begin
                collect_read(16'($urandom), 1'b1);
                total++; if (read_to || got_n !== N || !stall_ok) begin
                    bad++; $display("FAIL rand_read got=%0d/%0d exp=%0d/1", got_n, stall_ok, N);
                end
                for (int i = 0; i < N && i < got_n; i++) begin
                    total++; if (got_data[i] !== mdl_entry(i)) begin
                        bad++; $display("FAIL rand_read_beat%0d got=%h exp=%h", i, got_data[i], mdl_entry(i));
                    end
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        int cyc;
        bit held;
        s_valid  = 1'b1;
        cmp_trig = 1'b1;
        cmp_rsel = 2'd2;
        cmp_dout = {2'd0, 8'd9, 16'h0005};
        step();
        s_valid  = 1'b0;
        cmp_trig = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mdl_reset();
        total++; if (max_out !== 26'h000FFFF || s_ready !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0) begin
            bad++; $display("FAIL rst_scan got=%h/%b/%b/%b/%b exp=000ffff/1/0/0/0", max_out, s_ready, busy, m_valid, m_last);
        end
        for (int i = 0; i < N; i++) do_write(i, 16 + i, 100 * (i + 1), 1, 1'b0, cyc, held);
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        m_ready  = 1'b1;
        step();
        m_ready  = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        mdl_reset();
        total++; if (max_out !== 26'h000FFFF || s_ready !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0) begin
            bad++; $display("FAIL rst_read got=%h/%b/%b/%b/%b exp=000ffff/1/0/0/0", max_out, s_ready, busy, m_valid, m_last);
        end
        collect_read(16'hFFFF, 1'b0);
        total++; if (read_to || got_n !== N) begin bad++; $display("FAIL rst_readback_beats got=%0d exp=%0d", got_n, N); end
        for (int i = 0; i < N && i < got_n; i++) begin
            total++; if (got_data[i] !== mdl_entry(i)) begin
                bad++; $display("FAIL rst_readback%0d got=%h exp=%h", i, got_data[i], mdl_entry(i));
            end
        end
    endtask

    task automatic test_clr();
        int cyc;
        bit held;
        for (int i = 0; i < N; i++) do_write(i, 40 + i, 7 * (i + 2), 2, 1'b0, cyc, held);
        clr      = 1'b1;
        s_valid  = 1'b1;
        cmp_trig = 1'b1;
        cmp_rsel = 2'd1;
        cmp_dout = {2'd1, 8'd1, 16'h0001};
        rd_start = 1'b1;
        step();
        clr      = 1'b0;
        s_valid  = 1'b0;
        cmp_trig = 1'b0;
        rd_start = 1'b0;
        mdl_reset();
        total++; if (max_out !== 26'h000FFFF || busy !== 1'b0 || s_ready !== 1'b1 || m_valid !== 1'b0) begin
            bad++; $display("FAIL clr_state got=%h/%b/%b/%b exp=000ffff/0/1/0", max_out, busy, s_ready, m_valid);
        end
        collect_read(16'hAAAA, 1'b0);
        total++; if (read_to || got_n !== N) begin bad++; $display("FAIL clr_beats got=%0d exp=%0d", got_n, N); end
        for (int i = 0; i < N && i < got_n; i++) begin
            total++; if (got_data[i] !== mdl_entry(i)) begin
                bad++; $display("FAIL clr_readback%0d got=%h exp=%h", i, got_data[i], mdl_entry(i));
            end
        end
    endtask

    initial begin
        mdl_reset();
        test_reset();
        test_single_write();
        test_fill();
        test_readout();
        test_random();
        test_rst_mid();
        test_clr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/margin_regbank.md
MARGIN_REGBANK -- requirements
Module: margin_regbank

Interface
REQ-001 Parameter DATA_WIDTH, default 16, margin value width.
REQ-002 Parameter INDX_WIDTH, default 8, sample index width.
REQ-003 Parameter ADDR_WIDTH, default 2, slot address width; SHALL equal $clog2(N_REGISTERS).
REQ-004 Parameter N_REGISTERS, default 4, number of retained entries (K of top-K smallest margins).
REQ-005 One clock; reset is synchronous and active-high. Port: clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset.
REQ-007 s_valid  input  1  sample presented to the comparator this cycle.
REQ-008 s_ready  output  1  block able to accept a sample.
REQ-009 cmp_trig  input  1  comparator result: new margin < current max.
REQ-010 cmp_rsel  input  ADDR_WIDTH  slot to overwrite.
REQ-011 cmp_dout  input  DATA_WIDTH+INDX_WIDTH+ADDR_WIDTH  entry to write: {addr, index, margin}.
REQ-012 max_out  output  DATA_WIDTH+INDX_WIDTH+ADDR_WIDTH  current largest entry {addr, index, margin}, driven to the comparator.
REQ-013 rd_start  input  1  pulse: begin readout of all slots.
REQ-014 clr  input  1  pulse: return all slots to initial contents.
REQ-015 m_valid / m_ready  output / input  1 / 1  readout handshake.
REQ-016 m_data  output  DATA_WIDTH+INDX_WIDTH+ADDR_WIDTH  readout entry.
REQ-017 m_last  output  1  high with the final readout beat.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 Storage: N_REGISTERS entries; entry i initial value = {i, index 0, margin all-ones}.
REQ-020 FSM states: IDLE, SCAN, READ; s_ready = 1 only in IDLE.
REQ-021 IDLE, s_valid & cmp_trig: slot cmp_rsel written with cmp_dout on that edge; next state SCAN.
REQ-022 IDLE, s_valid & !cmp_trig: no write, stay IDLE, no stall.
REQ-023 SCAN: visits slots 0..N_REGISTERS-1, one per cycle (N_REGISTERS cycles); running max replaced only on strictly greater margin, so ties resolve to lowest address.
REQ-024 SCAN end: max_out updated with the winning entry on the last scan edge; next state IDLE; s_ready high the following cycle.
REQ-025 max_out SHALL hold its value throughout SCAN; it changes only at scan completion, reset or clr.
REQ-026 Stored address field: the written entry's address field SHALL be forced to cmp_rsel regardless of the cmp_dout address bits.
REQ-027 IDLE, rd_start (with s_valid low or !cmp_trig): next state READ, pointer = 0; if s_valid & cmp_trig in the same cycle, the write and SCAN take priority and rd_start is dropped.
REQ-028 READ: m_valid = 1, m_data = slot[pointer]; pointer advances on m_valid & m_ready; m_last = 1 when pointer = N_REGISTERS-1; handshake on last beat returns to IDLE.
REQ-029 READ: m_data and m_last stable while m_valid & !m_ready; s_valid, rd_start and cmp_* ignored.
REQ-030 clr accepted only in IDLE: all slots to REQ-019 values and max_out = {0, 0, all-ones} in one cycle; clr has priority over write and rd_start; ignored in SCAN/READ.
REQ-031 Sorting is not performed; readout order is slot address order.

Reset
REQ-032 rst SHALL override all activity in any state, including mid-SCAN or mid-READ: state IDLE, slots per REQ-019, max_out = {0, 0, all-ones}, s_ready = 1 the cycle after rst deasserts, m_valid = 0, m_last = 0, busy = 0, pointers 0.

Verification
REQ-033 Reset, N=4: max_out = 0x00_00_FFFF with addr 0; s_ready = 1; busy = 0.
REQ-034 Write margin 0x0010 idx 5 to slot 0 -> busy for 4 cycles; max_out = {addr 1, idx 0, 0xFFFF} (tie to lowest address); s_ready returns.
REQ-035 Fill slots with margins 0x30, 0x10, 0x20, 0x40 -> max_out margin 0x40 addr 3; sample with !cmp_trig -> no stall, no change.
REQ-036 rd_start with m_ready toggling 1,0,1,1,1 -> four beats in address order, data stable during stall, m_last on beat 4, IDLE after.
REQ-037 rst asserted mid-SCAN and mid-READ -> all outputs at REQ-032 values next cycle; clr in IDLE after fills -> initial contents readback.
